// File: rtl/mlp_seq_pkg.sv
// rtl/mlp_seq_pkg.sv - shared constants, state encoding and SRAM address helpers for the MLP host sequencer
package mlp_seq_pkg;
  localparam int NUM_LAYERS     = 8;
  localparam int ROWS           = 16;
  localparam int BEATS_PER_ROW  = 8;
  localparam int WBLKS          = 8;
  localparam int BEATS_PER_WBLK = 8;
  localparam int RESULT_BEATS   = 256;
  localparam int ADDR_W         = 12;
  localparam int TIMEOUT        = 4096;

  localparam logic LOAD_TYPE_INPUT  = 1'b1;
  localparam logic LOAD_TYPE_WEIGHT = 1'b0;

  localparam logic [ADDR_W-1:0] WEIGHT_BASE = 12'h000;
  localparam logic [ADDR_W-1:0] INPUT_BASE  = 12'h200;
  localparam logic [ADDR_W-1:0] RESULT_BASE = 12'h300;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WEIGHT,
    ST_INPUT,
    ST_DRAIN,
    ST_WAIT_RES,
    ST_COLLECT,
    ST_DONE
  } seq_state_e;

  function automatic logic [ADDR_W-1:0] weight_addr(input logic [2:0] layer, input logic [2:0] blk,
                                                    input logic [2:0] beat);
    return WEIGHT_BASE + {3'b000, layer, blk, beat};
  endfunction

  function automatic logic [ADDR_W-1:0] input_addr(input logic [3:0] row, input logic [2:0] beat);
    return INPUT_BASE + {5'b00000, row, beat};
  endfunction
endpackage

// File: rtl/mlp_result_collector.sv
// rtl/mlp_result_collector.sv - result timeout, beat counting, SRAM write port and stray/overflow error flag
module mlp_result_collector
  import mlp_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_wait,
  input  logic              in_collect,
  input  logic              result_valid_i,
  input  logic [31:0]       result_payload_i,
  output logic              first_beat,
  output logic              last_beat,
  output logic              timeout,
  output logic              mem_wr_en_o,
  output logic [ADDR_W-1:0] mem_wr_addr_o,
  output logic [31:0]       mem_wr_data_o,
  output logic              error_o
);
  localparam int BCW = $clog2(RESULT_BEATS);
  localparam int TW  = $clog2(TIMEOUT);

  logic [BCW-1:0] beat_cnt;
  logic [TW-1:0]  tmr;
  logic           accept;

  assign accept     = result_valid_i && (in_wait || in_collect);
  assign first_beat = in_wait && result_valid_i;
  assign last_beat  = accept && (beat_cnt == BCW'(RESULT_BEATS - 1));
  assign timeout    = in_wait && !result_valid_i && (tmr == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt      <= '0;
      tmr           <= '0;
      mem_wr_en_o   <= 1'b0;
      mem_wr_addr_o <= '0;
      mem_wr_data_o <= '0;
      error_o       <= 1'b0;
    end else begin
      mem_wr_en_o <= accept;
      if (accept) begin
        mem_wr_addr_o <= RESULT_BASE + ADDR_W'(beat_cnt);
        mem_wr_data_o <= result_payload_i;
        beat_cnt      <= beat_cnt + 1'b1;
      end
      if (clear) beat_cnt <= '0;
      tmr <= in_wait ? tmr + 1'b1 : '0;
      // A beat arriving while not collecting is dropped but flagged; flagging outranks the clear
      if (clear) error_o <= 1'b0;
      if ((result_valid_i && !(in_wait || in_collect)) || timeout) error_o <= 1'b1;
    end
  end
endmodule

// File: rtl/mlp_host_sequencer.sv
// rtl/mlp_host_sequencer.sv - streams weights/inputs from SRAM to the MLP accelerator and stores its results
module mlp_host_sequencer
  import mlp_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              hold_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  input  logic [31:0]       mem_rd_data_i,
  output logic              mem_wr_en_o,
  output logic [ADDR_W-1:0] mem_wr_addr_o,
  output logic [31:0]       mem_wr_data_o,
  output logic              load_en_o,
  output logic [31:0]       load_payload_o,
  output logic              load_type_o,
  output logic [3:0]        input_load_number_o,
  output logic [2:0]        layer_number_o,
  output logic [2:0]        weight_number_o,
  input  logic              result_valid_i,
  input  logic [31:0]       result_payload_i
);
  seq_state_e state_q;
  logic [2:0] layer_q, wblk_q, beat_q;
  logic [3:0] row_q;
  logic       in_load, issue, rd_issue, start_accept;
  logic       first_beat, last_beat, timeout;
  logic       beat_vld_q, from_mem_q, type_q;
  logic [3:0] row_out_q;
  logic [2:0] layer_out_q, wblk_out_q;

  assign start_accept = start_i && (state_q == ST_IDLE);
  assign in_load      = (state_q == ST_WEIGHT) || (state_q == ST_INPUT);
  assign issue        = in_load && !hold_i;
  // Later layers take inputs from accelerator feedback, so only layer 0 input beats touch SRAM
  assign rd_issue     = issue && ((state_q == ST_WEIGHT) || (layer_q == 3'd0));

  assign mem_rd_en_o   = rd_issue;
  assign mem_rd_addr_o = !rd_issue ? '0 :
                         (state_q == ST_WEIGHT) ? weight_addr(layer_q, wblk_q, beat_q) :
                                                  input_addr(row_q, beat_q);

  assign load_en_o           = beat_vld_q;
  assign load_payload_o      = (beat_vld_q && from_mem_q) ? mem_rd_data_i : 32'h0;
  assign load_type_o         = type_q;
  assign input_load_number_o = row_out_q;
  assign layer_number_o      = layer_out_q;
  assign weight_number_o     = wblk_out_q;
  assign busy_o              = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o              = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      layer_q <= '0;
      wblk_q  <= '0;
      row_q   <= '0;
      beat_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i) begin
          state_q <= ST_WEIGHT;
          layer_q <= '0;
          wblk_q  <= '0;
          row_q   <= '0;
          beat_q  <= '0;
        end
        ST_WEIGHT: if (issue) begin
          beat_q <= beat_q + 3'd1;
          if (beat_q == 3'(BEATS_PER_WBLK - 1)) begin
            wblk_q <= wblk_q + 3'd1;
            if (wblk_q == 3'(WBLKS - 1)) state_q <= ST_INPUT;
          end
        end
        ST_INPUT: if (issue) begin
          beat_q <= beat_q + 3'd1;
          if (beat_q == 3'(BEATS_PER_ROW - 1)) begin
            row_q <= row_q + 4'd1;
            if (row_q == 4'(ROWS - 1)) begin
              if (layer_q == 3'(NUM_LAYERS - 1)) begin
                state_q <= ST_DRAIN;
              end else begin
                layer_q <= layer_q + 3'd1;
                state_q <= ST_WEIGHT;
              end
            end
          end
        end
        ST_DRAIN:    state_q <= ST_WAIT_RES;
        ST_WAIT_RES: if (timeout) state_q <= ST_DONE;
                     else if (first_beat) state_q <= ST_COLLECT;
        ST_COLLECT:  if (last_beat) state_q <= ST_DONE;
        ST_DONE:     state_q <= ST_IDLE;
        default:     state_q <= ST_IDLE;
      endcase
    end
  end

  // Metadata is captured from the issue-cycle counters so it lines up with the returning read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_vld_q  <= 1'b0;
      from_mem_q  <= 1'b0;
      type_q      <= 1'b0;
      row_out_q   <= '0;
      layer_out_q <= '0;
      wblk_out_q  <= '0;
    end else begin
      beat_vld_q <= issue;
      if (issue) begin
        from_mem_q  <= rd_issue;
        type_q      <= (state_q == ST_INPUT) ? LOAD_TYPE_INPUT : LOAD_TYPE_WEIGHT;
        row_out_q   <= row_q;
        layer_out_q <= layer_q;
        wblk_out_q  <= wblk_q;
      end
    end
  end

  mlp_result_collector u_collector (
    .clk              (clk),
    .rst_n            (rst_n),
    .clear            (start_accept),
    .in_wait          (state_q == ST_WAIT_RES),
    .in_collect       (state_q == ST_COLLECT),
    .result_valid_i   (result_valid_i),
    .result_payload_i (result_payload_i),
    .first_beat       (first_beat),
    .last_beat        (last_beat),
    .timeout          (timeout),
    .mem_wr_en_o      (mem_wr_en_o),
    .mem_wr_addr_o    (mem_wr_addr_o),
    .mem_wr_data_o    (mem_wr_data_o),
    .error_o          (error_o)
  );
endmodule
